// File: rtl/hazard_forward_unit_if.sv
// Bundle of the ID/EX/MEM/WB hazard signals exchanged with hazard_forward_unit.
// The pipeline side uses the master view and the unit uses the slave view.
interface hazard_forward_unit_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
);
    logic              id_valid;
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic              id_uses_rs1;
    logic              id_uses_rs2;
    logic [REG_AW-1:0] id_rd;
    logic              id_RegWrite;
    logic              id_is_mc;
    logic              ex_flush;
    logic [REG_AW-1:0] id_ex_rs1;
    logic [REG_AW-1:0] id_ex_rs2;
    logic [REG_AW-1:0] id_ex_rd;
    logic              id_ex_MemRead;
    logic [REG_AW-1:0] ex_mem_rd;
    logic              ex_mem_RegWrite;
    logic [REG_AW-1:0] mem_wb_rd;
    logic              mem_wb_RegWrite;
    logic              mc_wb_valid;
    logic [REG_AW-1:0] mc_wb_rd;
    logic              stat_clr;
    logic [1:0]        forward_a;
    logic [1:0]        forward_b;
    logic              stall;
    logic              bubble_id_ex;
    logic [1:0]        stall_cause;
    logic [CNT_W-1:0]  stall_count;

    modport master (
        output id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_rd,
               id_RegWrite, id_is_mc, ex_flush, id_ex_rs1, id_ex_rs2, id_ex_rd,
               id_ex_MemRead, ex_mem_rd, ex_mem_RegWrite, mem_wb_rd,
               mem_wb_RegWrite, mc_wb_valid, mc_wb_rd, stat_clr,
        input  forward_a, forward_b, stall, bubble_id_ex, stall_cause, stall_count
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_rd,
               id_RegWrite, id_is_mc, ex_flush, id_ex_rs1, id_ex_rs2, id_ex_rd,
               id_ex_MemRead, ex_mem_rd, ex_mem_RegWrite, mem_wb_rd,
               mem_wb_RegWrite, mc_wb_valid, mc_wb_rd, stat_clr,
        output forward_a, forward_b, stall, bubble_id_ex, stall_cause, stall_count
    );
endinterface

// File: rtl/hazard_forward_unit.sv
// EX operand forwarding plus load-use, multi-cycle scoreboard and structural
// stall detection, with a saturating count of stalled cycles.
module hazard_forward_unit #(
    parameter int REG_AW = 5,
    parameter int MC_LAT = 4,
    parameter int CNT_W  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    hazard_forward_unit_if.slave  bus
);
    localparam int NREG = 1 << REG_AW;

    typedef enum logic [1:0] {
        CAUSE_NONE = 2'b00,
        CAUSE_LU   = 2'b01,
        CAUSE_SB   = 2'b10,
        CAUSE_ST   = 2'b11
    } cause_e;

    logic [NREG-1:0]  busy_q, busy_d;
    logic [3:0]       mc_cnt_q, mc_cnt_d;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;

    logic [NREG-1:0] eff_busy;
    logic            live, lu, sb, st, stall_raw, issue;
    cause_e          cause;
    logic [1:0]      fwd_a, fwd_b;

    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (bus.ex_mem_RegWrite && bus.ex_mem_rd != '0 && bus.ex_mem_rd == bus.id_ex_rs1)
            fwd_a = 2'b10;
        else if (bus.mem_wb_RegWrite && bus.mem_wb_rd != '0 && bus.mem_wb_rd == bus.id_ex_rs1)
            fwd_a = 2'b01;
        if (bus.ex_mem_RegWrite && bus.ex_mem_rd != '0 && bus.ex_mem_rd == bus.id_ex_rs2)
            fwd_b = 2'b10;
        else if (bus.mem_wb_RegWrite && bus.mem_wb_rd != '0 && bus.mem_wb_rd == bus.id_ex_rs2)
            fwd_b = 2'b01;
    end

    // A result writing back this cycle reaches ID through the write-through
    // register file, so its busy bit no longer blocks readers or writers.
    always_comb begin
        eff_busy = busy_q;
        if (bus.mc_wb_valid)
            eff_busy[bus.mc_wb_rd] = 1'b0;
        live = bus.id_valid && !bus.ex_flush;
        lu = live && bus.id_ex_MemRead && bus.id_ex_rd != '0 &&
             ((bus.id_uses_rs1 && bus.id_rs1 == bus.id_ex_rd) ||
              (bus.id_uses_rs2 && bus.id_rs2 == bus.id_ex_rd));
        sb = live && ((bus.id_uses_rs1 && eff_busy[bus.id_rs1]) ||
                      (bus.id_uses_rs2 && eff_busy[bus.id_rs2]) ||
                      (bus.id_RegWrite && eff_busy[bus.id_rd]));
        st = live && bus.id_is_mc && mc_cnt_q != 4'd0;
        stall_raw = lu || sb || st;
        issue = live && !stall_raw && bus.id_is_mc;
        if (lu)
            cause = CAUSE_LU;
        else if (sb)
            cause = CAUSE_SB;
        else if (st)
            cause = CAUSE_ST;
        else
            cause = CAUSE_NONE;
    end

    always_comb begin
        mc_cnt_d = mc_cnt_q;
        if (issue)
            mc_cnt_d = 4'(MC_LAT);
        else if (mc_cnt_q != 4'd0)
            mc_cnt_d = mc_cnt_q - 4'd1;

        // Clear first so that an issue to the same register wins.
        busy_d = busy_q;
        if (bus.mc_wb_valid)
            busy_d[bus.mc_wb_rd] = 1'b0;
        if (issue && bus.id_RegWrite && bus.id_rd != '0)
            busy_d[bus.id_rd] = 1'b1;
        busy_d[0] = 1'b0;

        stall_count_d = stall_count_q;
        if (bus.stat_clr)
            stall_count_d = '0;
        else if (stall_raw && !(&stall_count_q))
            stall_count_d = stall_count_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q        <= '0;
            mc_cnt_q      <= 4'd0;
            stall_count_q <= '0;
        end else begin
            busy_q        <= busy_d;
            mc_cnt_q      <= mc_cnt_d;
            stall_count_q <= stall_count_d;
        end
    end

    always_comb begin
        bus.forward_a    = rst ? 2'b00 : fwd_a;
        bus.forward_b    = rst ? 2'b00 : fwd_b;
        bus.stall        = !rst && stall_raw;
        bus.bubble_id_ex = !rst && stall_raw;
        bus.stall_cause  = rst ? CAUSE_NONE : cause;
        bus.stall_count  = rst ? '0 : stall_count_q;
    end
endmodule
